// File: rtl/clz_norm_sched.sv
// rtl/clz_norm_sched.sv - round-robin shared clz32 + left normaliser, 2-stage pipeline
module clz_norm_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDW-1:0]    out_id,
    output logic [31:0]       out_norm,
    output logic [5:0]        out_lz,
    output logic              out_zero
);

    // Position of the highest set bit decides the count; an all-zero word yields 32.
    function automatic logic [5:0] clz32(input logic [31:0] d);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    logic            s1_valid_q;
    logic [31:0]     s1_data_q;
    logic [IDW-1:0]  s1_id_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;

    logic            out_valid_q;
    logic [IDW-1:0]  out_id_q;
    logic [31:0]     out_norm_q;
    logic [5:0]      out_lz_q;
    logic            out_zero_q;

    logic            adv1;
    logic            adv2;
    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [31:0]     grant_data;
    logic            xfer;
    logic [5:0]      s1_lz;
    logic [31:0]     s1_norm;

    assign adv2 = !out_valid_q || out_ready;
    assign adv1 = !s1_valid_q || adv2;

    always_comb begin
        int idx;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = IDW'(idx);
                grant_data = req_data[32*idx +: 32];
            end
        end
    end

    // Grant is suppressed while rst is asserted so no handshake can complete during reset.
    assign xfer      = grant_vld && adv1 && !rst;
    assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;
    assign ptr_d     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    assign s1_lz   = clz32(s1_data_q);
    assign s1_norm = s1_lz[5] ? 32'd0 : (s1_data_q << s1_lz[4:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_norm_q  <= '0;
            out_lz_q    <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            if (xfer) begin
                ptr_q <= ptr_d;
            end
            if (adv1) begin
                s1_valid_q <= xfer;
                if (xfer) begin
                    s1_data_q <= grant_data;
                    s1_id_q   <= grant_idx;
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_lz_q   <= s1_lz;
                    out_norm_q <= s1_norm;
                    out_zero_q <= s1_lz[5];
                    out_id_q   <= s1_id_q;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_norm  = out_norm_q;
    assign out_lz    = out_lz_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_clz_norm_sched.sv
// tb/tb_clz_norm_sched.sv - directed self-checking bench for clz_norm_sched
module tb_clz_norm_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [IDW-1:0]     out_id;
    logic [31:0]        out_norm;
    logic [5:0]         out_lz;
    logic               out_zero;

    int n_cmp;
    int n_err;

    clz_norm_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_norm  (out_norm),
        .out_lz    (out_lz),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int idx, input logic [31:0] d, input logic [5:0] lz,
                          input logic [31:0] norm, input logic zero);
        req_valid = NREQ'(1) << idx;
        req_data[32*idx +: 32] = d;
        #1;
        chk("single_ready", 32'(req_ready), 32'(NREQ'(1) << idx));
        tick();
        req_valid = '0;
        #1;
        chk("single_ready_drop", 32'(req_ready), 32'd0);
        chk("single_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_id", 32'(out_id), 32'(idx));
        chk("single_lz", 32'(lz), 32'(out_lz) == 32'(lz) ? 32'(lz) : 32'(out_lz) ^ 32'h100);
        chk("single_lz_val", 32'(out_lz), 32'(lz));
        chk("single_norm", out_norm, norm);
        chk("single_zero", 32'(out_zero), 32'(zero));
        tick();
        chk("single_idle", 32'(out_valid), 32'd0);
    endtask

    logic [31:0] a_hist [32];
    int          r_hist [32];
    int          acc;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b1;

        // Reset held with random traffic
        for (int c = 0; c < 4; c++) begin
            req_valid = NREQ'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("rst_ready", 32'(req_ready), 32'd0);
            tick();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_norm", out_norm, 32'd0);
        chk("rst_out_lz", 32'(out_lz), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);

        rst = 1'b0;
        req_valid = 4'b0110;
        req_data[63:32] = 32'h00F0_0000;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_id", 32'(out_id), 32'd1);
        chk("first_lz", 32'(out_lz), 32'd8);
        chk("first_norm", out_norm, 32'hF000_0000);
        tick();

        single(2, 32'h0001_0000, 6'd15, 32'h8000_0000, 1'b0);
        single(0, 32'h0000_0000, 6'd32, 32'h0000_0000, 1'b1);
        single(3, 32'h8000_0000, 6'd0,  32'h8000_0000, 1'b0);
        single(1, 32'h0000_0001, 6'd31, 32'h8000_0000, 1'b0);

        // Round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h1 << (8*i + 3);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k == 1) chk("rr_fill", 32'(out_valid), 32'd0);
            if (k >= 2) begin
                chk("rr_valid", 32'(out_valid), 32'd1);
                chk("rr_id", 32'(out_id), 32'((k - 2) % 4));
                chk("rr_lz", 32'(out_lz), 32'(28 - 8 * ((k - 2) % 4)));
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        chk("rr_drained", 32'(out_valid), 32'd0);

        // Backpressure: pointer now 2
        req_valid = 4'b1111;
        out_ready = 1'b0;
        acc = 0;
        for (int s = 0; s < 6; s++) begin
            #1;
            if (s == 0) chk("bp_grant0", 32'(req_ready), 32'b0100);
            if (s == 1) chk("bp_grant1", 32'(req_ready), 32'b1000);
            if (s >= 2) begin
                chk("bp_blocked", 32'(req_ready), 32'd0);
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_id", 32'(out_id), 32'd2);
                chk("bp_hold_lz", 32'(out_lz), 32'd12);
                chk("bp_hold_norm", out_norm, 32'h8000_0000);
            end
            if ((req_ready & req_valid) != '0) acc++;
            tick();
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            #1;
            chk("bp_rel_grant", 32'(req_ready), 32'(4'b0001 << (r % 4)));
            chk("bp_rel_valid", 32'(out_valid), 32'd1);
            chk("bp_rel_id", 32'(out_id), 32'((2 + r) % 4));
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        // Sweep of single-bit-led operands on random requesters
        for (int i = 0; i < 32; i++) begin
            logic [31:0] a;
            int          r;
            a = 32'h1 << i;
            if (i >= 1) a[i-1] = 1'($urandom);
            if (i >= 2) a[i-2] = 1'($urandom);
            r = int'($urandom_range(NREQ - 1, 0));
            a_hist[i] = a;
            r_hist[i] = r;
            req_valid = NREQ'(1) << r;
            req_data[32*r +: 32] = a;
            #1;
            chk("sw_grant", 32'(req_ready), 32'(NREQ'(1) << r));
            if (i >= 2) begin
                chk("sw_valid", 32'(out_valid), 32'd1);
                chk("sw_id", 32'(out_id), 32'(r_hist[i-2]));
                chk("sw_lz", 32'(out_lz), 32'(31 - (i - 2)));
                chk("sw_msb", 32'(out_norm[31]), 32'd1);
                chk("sw_norm", out_norm, a_hist[i-2] << (31 - (i - 2)));
            end
            tick();
        end
        chk("sw_tail_id", 32'(out_id), 32'(r_hist[30]));
        chk("sw_tail_lz", 32'(out_lz), 32'd1);

        // Reset mid-stream
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
